// File: rtl/player_move_scheduler.sv
// Turn sequencer for the two board sprites: accepts a dice move for the active player,
// walks that player along a serpentine board path one tile per FRAMES_PER_STEP frames.
//
// state | meaning
// IDLE  | waiting for a move request for the active player
// WAIT  | move in progress, counting frame_ticks between tile steps
// DONE  | one-cycle move_done pulse, hand over turn or end game
// OVER  | a player reached the goal tile, frozen until reset
module player_move_scheduler #(
    parameter int ORIGIN_X        = 64,
    parameter int ORIGIN_Y        = 48,
    parameter int TILE_W          = 32,
    parameter int TILE_H          = 32,
    parameter int COLS            = 8,
    parameter int ROWS            = 6,
    parameter int FRAMES_PER_STEP = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       move_valid,
    input  logic [2:0] move_steps,
    output logic       move_ready,
    output logic       move_done,
    output logic       busy,
    output logic       active_player,
    output logic       game_over,
    output logic       winner,
    output logic [9:0] p0_x,
    output logic [9:0] p0_y,
    output logic [9:0] p1_x,
    output logic [9:0] p1_y
);

    localparam int NUM_TILES = COLS * ROWS;
    localparam int TILE_BITS = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int COL_BITS  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_BITS  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FCNT_BITS = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [TILE_BITS-1:0] GOAL_TILE = TILE_BITS'(NUM_TILES - 1);
    localparam logic [COL_BITS-1:0]  LAST_COL  = COL_BITS'(COLS - 1);
    localparam logic [FCNT_BITS-1:0] FCNT_LAST = FCNT_BITS'(FRAMES_PER_STEP - 1);
    localparam logic [9:0]           X0        = 10'(ORIGIN_X);
    localparam logic [9:0]           Y0        = 10'(ORIGIN_Y);
    localparam logic [9:0]           DX        = 10'(TILE_W);
    localparam logic [9:0]           DY        = 10'(TILE_H);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2,
        OVER = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic                 active_q;
    logic                 game_over_q;
    logic                 winner_q;
    logic                 goal_q;
    logic [FCNT_BITS-1:0] fcnt_q;
    logic [2:0]           remaining_q;

    logic [ROW_BITS-1:0]  row_q  [2];
    logic [COL_BITS-1:0]  col_q  [2];
    logic [TILE_BITS-1:0] tile_q [2];
    logic [9:0]           x_q    [2];
    logic [9:0]           y_q    [2];

    logic [ROW_BITS-1:0]  cur_row, nxt_row;
    logic [COL_BITS-1:0]  cur_col, nxt_col;
    logic [TILE_BITS-1:0] cur_tile, nxt_tile;
    logic [9:0]           cur_x, nxt_x;
    logic [9:0]           cur_y, nxt_y;
    logic                 step_en;
    logic                 step_goal;
    logic [2:0]           rem_dec;

    assign cur_row  = row_q[active_q];
    assign cur_col  = col_q[active_q];
    assign cur_tile = tile_q[active_q];
    assign cur_x    = x_q[active_q];
    assign cur_y    = y_q[active_q];

    // Serpentine walk: even rows run left-to-right, odd rows right-to-left, row ends drop down.
    always_comb begin
        nxt_row  = cur_row;
        nxt_col  = cur_col;
        nxt_x    = cur_x;
        nxt_y    = cur_y;
        nxt_tile = cur_tile + TILE_BITS'(1);
        if (!cur_row[0]) begin
            if (cur_col == LAST_COL) begin
                nxt_row = cur_row + ROW_BITS'(1);
                nxt_y   = cur_y + DY;
            end else begin
                nxt_col = cur_col + COL_BITS'(1);
                nxt_x   = cur_x + DX;
            end
        end else begin
            if (cur_col == '0) begin
                nxt_row = cur_row + ROW_BITS'(1);
                nxt_y   = cur_y + DY;
            end else begin
                nxt_col = cur_col - COL_BITS'(1);
                nxt_x   = cur_x - DX;
            end
        end
    end

    assign step_en   = (state_q == WAIT) && frame_tick && (fcnt_q == FCNT_LAST);
    assign step_goal = (nxt_tile == GOAL_TILE);
    assign rem_dec   = remaining_q - 3'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        move_ready = 1'b0;
        busy       = 1'b0;
        move_done  = 1'b0;
        case (state_q)
            IDLE: begin
                move_ready = 1'b1;
                if (move_valid) begin
                    state_d = (move_steps == 3'd0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (step_en && ((rem_dec == 3'd0) || step_goal)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                move_done = 1'b1;
                state_d   = goal_q ? OVER : IDLE;
            end
            OVER: begin
                state_d = OVER;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q    <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
            goal_q      <= 1'b0;
            fcnt_q      <= '0;
            remaining_q <= 3'd0;
            for (int i = 0; i < 2; i++) begin
                row_q[i]  <= '0;
                col_q[i]  <= '0;
                tile_q[i] <= '0;
                x_q[i]    <= X0;
                y_q[i]    <= Y0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (move_valid) begin
                        remaining_q <= move_steps;
                        fcnt_q      <= '0;
                        goal_q      <= 1'b0;
                    end
                end
                WAIT: begin
                    if (frame_tick) begin
                        if (fcnt_q == FCNT_LAST) begin
                            fcnt_q           <= '0;
                            row_q[active_q]  <= nxt_row;
                            col_q[active_q]  <= nxt_col;
                            tile_q[active_q] <= nxt_tile;
                            x_q[active_q]    <= nxt_x;
                            y_q[active_q]    <= nxt_y;
                            // Landing on the goal throws away any overshoot.
                            remaining_q      <= step_goal ? 3'd0 : rem_dec;
                            goal_q           <= step_goal;
                        end else begin
                            fcnt_q <= fcnt_q + FCNT_BITS'(1);
                        end
                    end
                end
                DONE: begin
                    if (goal_q) begin
                        game_over_q <= 1'b1;
                        winner_q    <= active_q;
                    end else begin
                        active_q <= ~active_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign active_player = active_q;
    assign game_over     = game_over_q;
    assign winner        = winner_q;
    assign p0_x          = x_q[0];
    assign p0_y          = y_q[0];
    assign p1_x          = x_q[1];
    assign p1_y          = y_q[1];

endmodule
